// File: rtl/mont_mul_ctrl_pkg.sv
// Shared definitions for the bit-serial Montgomery multiplier controller:
// operand/counter widths, FSM state encoding and adder opcode values.
package mont_mul_ctrl_pkg;

   localparam int OP_WIDTH  = 512;
   localparam int CNT_WIDTH = 9;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(OP_WIDTH - 1);

   localparam logic ADD_OP = 1'b0;
   localparam logic SUB_OP = 1'b1;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      ITER   = 4'd1,
      ADD_B  = 4'd2,
      WAIT_B = 4'd3,
      CHK_M  = 4'd4,
      ADD_M  = 4'd5,
      WAIT_M = 4'd6,
      SHIFT  = 4'd7,
      SUB    = 4'd8,
      WAIT_S = 4'd9,
      DONE   = 4'd10
   } state_e;

endpackage

// File: rtl/mont_mul_ctrl.sv
// Radix-2 interleaved Montgomery multiplier controller: result = A*B*2^-512 mod M.
// All wide additions/subtractions are delegated to the shared external adder.
module mont_mul_ctrl
   import mont_mul_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                resetn,
   input  logic                start,
   input  logic [OP_WIDTH-1:0] in_a,
   input  logic [OP_WIDTH-1:0] in_b,
   input  logic [OP_WIDTH-1:0] in_m,
   output logic [OP_WIDTH-1:0] result,
   output logic                done,
   output logic                add_start,
   output logic                add_subtract,
   output logic [OP_WIDTH:0]   add_in_a,
   output logic [OP_WIDTH:0]   add_in_b,
   input  logic [OP_WIDTH+1:0] add_result,
   input  logic                add_done
);

   state_e                 state_r;
   logic [OP_WIDTH-1:0]    a_r;
   logic [OP_WIDTH-1:0]    b_r;
   logic [OP_WIDTH-1:0]    m_r;
   logic [OP_WIDTH:0]      c_r;
   logic [CNT_WIDTH-1:0]   cnt_r;
   logic [OP_WIDTH-1:0]    res_r;

   assign result = res_r;

   // Controller FSM: sequencing, accumulator update and registered adder interface.
   always_ff @(posedge clk) begin
      if (resetn) begin
         state_r      <= IDLE;
         a_r          <= {OP_WIDTH{1'b0}};
         b_r          <= {OP_WIDTH{1'b0}};
         m_r          <= {OP_WIDTH{1'b0}};
         c_r          <= {(OP_WIDTH+1){1'b0}};
         cnt_r        <= {CNT_WIDTH{1'b0}};
         res_r        <= {OP_WIDTH{1'b0}};
         done         <= 1'b0;
         add_start    <= 1'b0;
         add_subtract <= ADD_OP;
         add_in_a     <= {(OP_WIDTH+1){1'b0}};
         add_in_b     <= {(OP_WIDTH+1){1'b0}};
      end else begin
         add_start <= 1'b0;
         done      <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  a_r     <= in_a;
                  b_r     <= in_b;
                  m_r     <= in_m;
                  c_r     <= {(OP_WIDTH+1){1'b0}};
                  cnt_r   <= {CNT_WIDTH{1'b0}};
                  state_r <= ITER;
               end else begin
                  state_r <= IDLE;
               end
            end
            ITER: begin
               if (a_r[0]) begin
                  state_r <= ADD_B;
               end else begin
                  state_r <= CHK_M;
               end
            end
            ADD_B: begin
               add_in_a     <= c_r;
               add_in_b     <= {1'b0, b_r};
               add_subtract <= ADD_OP;
               add_start    <= 1'b1;
               state_r      <= WAIT_B;
            end
            WAIT_B: begin
               if (add_done) begin
                  c_r     <= add_result[OP_WIDTH:0];
                  state_r <= CHK_M;
               end else begin
                  state_r <= WAIT_B;
               end
            end
            CHK_M: begin
               if (c_r[0]) begin
                  state_r <= ADD_M;
               end else begin
                  state_r <= SHIFT;
               end
            end
            ADD_M: begin
               add_in_a     <= c_r;
               add_in_b     <= {1'b0, m_r};
               add_subtract <= ADD_OP;
               add_start    <= 1'b1;
               state_r      <= WAIT_M;
            end
            WAIT_M: begin
               if (add_done) begin
                  c_r     <= add_result[OP_WIDTH:0];
                  state_r <= SHIFT;
               end else begin
                  state_r <= WAIT_M;
               end
            end
            SHIFT: begin
               c_r   <= c_r >> 1;
               a_r   <= a_r >> 1;
               cnt_r <= cnt_r + CNT_WIDTH'(1);
               if (cnt_r == CNT_LAST) begin
                  state_r <= SUB;
               end else begin
                  state_r <= ITER;
               end
            end
            SUB: begin
               add_in_a     <= c_r;
               add_in_b     <= {1'b0, m_r};
               add_subtract <= SUB_OP;
               add_start    <= 1'b1;
               state_r      <= WAIT_S;
            end
            WAIT_S: begin
               // A set sign bit means C < M, so the accumulator is already reduced.
               if (add_done) begin
                  if (add_result[OP_WIDTH+1]) begin
                     res_r <= c_r[OP_WIDTH-1:0];
                  end else begin
                     res_r <= add_result[OP_WIDTH-1:0];
                  end
                  done    <= 1'b1;
                  state_r <= DONE;
               end else begin
                  state_r <= WAIT_S;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mont_mul_ctrl.md
Name: mont_mul_ctrl

Overview:
- Bit-serial Montgomery multiplier: computes result = A·B·2^-512 mod M (radix-2 interleaved Montgomery, 512 iterations).
- Sits directly upstream of the shared multi-cycle 512-bit adder/subtractor: it issues every wide add/subtract to that adder via a start/done handshake and consumes its 514-bit result.
- Owns the accumulator, the iteration counter and the final conditional subtraction. It has no arithmetic wider than a bit test and a shift of its own.

Parameters:
- OP_WIDTH, 512, operand width; fixed to the adder width, not meant to be overridden.
- CNT_WIDTH, 9, iteration counter width (log2 OP_WIDTH).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- resetn  in  1  synchronous, active-high reset (1 = reset), sampled on rising clk.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- in_a  in  512  multiplicand A, captured on accepted start.
- in_b  in  512  multiplier B, captured on accepted start.
- in_m  in  512  modulus M, captured on accepted start.
- result  out  512  product, valid from the done cycle until the next accepted start.
- done  out  1  one-cycle pulse when result is valid.
- add_start  out  1  one-cycle pulse launching one adder operation.
- add_subtract  out  1  1 = in_a − in_b, 0 = in_a + in_b; held stable until add_done.
- add_in_a  out  513  adder operand A; held stable from add_start through add_done.
- add_in_b  out  513  adder operand B; held stable from add_start through add_done.
- add_result  in  514  adder result, read only in the cycle add_done is high.
- add_done  in  1  one-cycle adder completion pulse.

Behaviour:
- Preconditions, not checked in RTL: M odd; M < 2^511; A < M; B < M. These keep every intermediate below 2^513.
- Registers:
  - a_reg (512, shifts right one bit per iteration)
  - b_reg, m_reg (512 each)
  - c_reg (513, accumulator)
  - cnt (CNT_WIDTH)
  - res_reg (512)
- Reset (resetn=1): state=IDLE; all registers 0; done=0; add_start=0; add_subtract=0; result=0. Reset asserted mid-operation aborts immediately. Any add_done arriving afterwards is ignored.
- States and transitions:
  - IDLE: on start, capture in_a/in_b/in_m, clear c_reg and cnt → ITER.
  - ITER: if a_reg[0]=1 → ADD_B, else → CHK_M.
  - ADD_B: drive add_in_a={c_reg}, add_in_b={1'b0,b_reg}, add_subtract=0; pulse add_start → WAIT_B.
  - WAIT_B: on add_done, c_reg ← add_result[512:0] → CHK_M.
  - CHK_M: if c_reg[0]=1 → ADD_M, else → SHIFT.
  - ADD_M: operands c_reg, {1'b0,m_reg}, add; pulse add_start → WAIT_M.
  - WAIT_M: on add_done, c_reg ← add_result[512:0] → SHIFT.
  - SHIFT: c_reg ← c_reg>>1; a_reg ← a_reg>>1; cnt ← cnt+1. If cnt=OP_WIDTH−1 → SUB, else → ITER.
  - SUB: operands c_reg, {1'b0,m_reg}, add_subtract=1; pulse add_start → WAIT_S.
  - WAIT_S: on add_done, res_reg ← (add_result[513]=1) ? c_reg[511:0] : add_result[511:0] → DONE. add_result[513]=1 means negative, i.e. C<M.
  - DONE: done=1 for exactly this cycle → IDLE.
- add_start is high for exactly one cycle per operation. A second add_start is never issued before the matching add_done.
- Operands and add_subtract are driven from registers and stay constant through each WAIT state.
- add_done outside a WAIT state is ignored.
- start outside IDLE is ignored; there is no queueing.
- For add operations add_result[513] must be 0. The bench asserts this.
- Latency, in adder operations: popcount(A) + (number of odd-accumulator iterations) + 1.
- Controller overhead: 2 cycles per iteration (ITER, SHIFT), plus 1 cycle per CHK_M, plus 2 cycles per adder call (issue state and capture cycle). Add to this the adder's own latency.
- Invariant after each SHIFT: c_reg < 2M.

Decomposition:
- Shared package holds:
  - OP_WIDTH, CNT_WIDTH;
  - the state encoding: IDLE, ITER, ADD_B, WAIT_B, CHK_M, ADD_M, WAIT_M, SHIFT, SUB, WAIT_S, DONE (4-bit);
  - ADD_OP / SUB_OP constants for add_subtract.
- No sub-module inside the block. The top-level instantiates mont_mul_ctrl beside the adder and wires the add_* ports.
- The testbench adder model is a separate behavioural module, mont_add_model, with configurable latency.

Test Plan:
- A=0, B=5, M=7 → result=0; exactly 1 add_start (final subtract only); done pulses once.
- A=1, B=1, M=7 → result=2, since 2^-512 mod 7 = 2.
- A=3, B=4, M=5 → result=2; add_start count equals 2 + odd-accumulator count + 1, cross-checked against a reference model.
- Random A, B < M, odd M < 2^511, adder model latency 1 and 10 → result matches a software Montgomery model. Every add_result[513]=0 on adds, and add_in_* stay stable across every WAIT.
- Reset pulse during WAIT_M, followed by a late add_done → state IDLE, done stays 0, no add_start. The next start with A=B=1, M=3 → result=1.
- start re-asserted while busy, and start held high for 3 cycles in IDLE → only one operation runs. result holds its value after done until the next accepted start.
